pc_sel_mux: RTL
===============

PC_SEL_MUX -- requirements
Module: pc_sel_mux

Interface
REQ-001 Parameter WIDTH, default 32, data width of every input and of the output.
REQ-002 Parameter NUM_IN, default 3, number of selectable inputs, legal range 2..16.
REQ-003 Parameter SEL_W, default 2, select width, equal to ceil(log2(NUM_IN)).
REQ-004 Parameter RESET_VAL, default 32'h00400030, output value after reset.
REQ-005 The design SHALL use one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
REQ-009 sel  input  SEL_W  index of the input to load.
REQ-010 sel_valid  input  1  sel is a load request this cycle.
REQ-011 stall  input  1  freeze the output; requests are buffered.
REQ-012 out  output  WIDTH  registered selected value.
REQ-013 out_valid  output  1  one-cycle pulse: out was updated at this edge.
REQ-014 pend  output  1  one-entry pending buffer is occupied.
REQ-015 err  output  1  sticky flag: an illegal select was seen.

Function
REQ-016 Latency SHALL be one cycle: a request accepted at edge N is visible on out after edge N.
REQ-017 With sel_valid=1, stall=0 and sel<NUM_IN: out <= in_data[sel] and out_valid <= 1.
REQ-018 With sel_valid=1, stall=1 and sel<NUM_IN: the selected value SHALL be captured into the pending buffer at that edge and pend <= 1; out holds and out_valid <= 0.
REQ-019 A second legal request during the same stall SHALL overwrite the pending buffer, so the newest request wins.
REQ-020 With stall=0, sel_valid=0 and pend=1: out <= pending value, out_valid <= 1, pend <= 0.
REQ-021 With stall=0, sel_valid=1 (legal) and pend=1: the new request SHALL win and pend <= 0; the pending value is discarded.
REQ-022 With no request, no pending value, or stall=1: out holds and out_valid <= 0.
REQ-023 sel >= NUM_IN with sel_valid=1: err <= 1 (held until reset), no update to out or the pending buffer, out_valid <= 0; an existing pending value is still drained per REQ-020 if stall=0.
REQ-024 Data SHALL be captured at the accepting edge; later changes on in_data do not alter a pending value.
REQ-025 sel and in_data SHALL be ignored whenever sel_valid=0.

Reset
REQ-026 While rst_n=0: out=RESET_VAL, out_valid=0, pend=0, err=0, pending buffer cleared; this takes effect immediately, independent of clk.
REQ-027 Reset mid-stall SHALL discard any pending value; the first post-reset edge behaves as in REQ-017..REQ-023.

Structure
REQ-028 Package pc_sel_pkg SHALL hold the RESET_VAL default constant (32'h00400030) and the maximum NUM_IN constant (16).
REQ-029 The one-entry pending buffer SHALL be a separate sub-module named pend_buf, with load, clear, data and occupied ports.
REQ-030 No simulation-only $display SHALL be used for illegal selects; reporting is through err only.

Verification
REQ-031 Reset release, no requests for 3 cycles -> out=0x00400030, out_valid=0, pend=0, err=0 throughout.
REQ-032 NUM_IN=3, in_data={0x30,0x20,0x10}, sel=2, sel_valid for 1 cycle -> next cycle out=0x30, out_valid=1; following cycle out_valid=0.
REQ-033 stall=1; request sel=1 (0x20), then sel=0 (0x10); stall=0 with no request -> pend=1 during stall, out unchanged, then out=0x10, out_valid=1, pend=0.
REQ-034 pend=1 holding 0x20; stall drops in the same cycle as a request sel=2 (0x30) -> out=0x30, pend=0, 0x20 never appears on out.
REQ-035 sel=3 with NUM_IN=3 -> err=1, out unchanged, out_valid=0; err stays 1 across later legal requests until rst_n=0.
REQ-036 rst_n asserted mid-stall with pend=1 -> out=0x00400030 and pend=0 asynchronously; after release, stall=0 with no request leaves out_valid=0.

Source files
------------

// File: rtl/pc_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pc_sel_pkg
// Brief    : Shared constants for the PC select multiplexer block.
// Revision : 1.0 - initial release
// ============================================================================
package pc_sel_pkg;

  // Value driven on the PC output while reset is asserted.
  localparam logic [31:0] c_PC_RESET_VAL = 32'h0040_0030;

  // Largest number of selectable inputs the block supports.
  localparam int c_MAX_NUM_IN = 16;

endpackage : pc_sel_pkg
`default_nettype wire

// File: rtl/pc_sel_mux_pend_buf.sv
`default_nettype none
// ============================================================================
// Module   : pend_buf
// Brief    : One-entry holding buffer for a load request that arrived while
//            the output was stalled. Load takes priority over clear.
// Revision : 1.0 - initial release
// ============================================================================
module pend_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_occupied
);

  logic [WIDTH-1:0] r_data;
  logic             r_occupied;

  // Capture on load (newest request overwrites), empty on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_occupied <= 1'b0;
    end else if (i_load) begin
      r_data     <= i_data;
      r_occupied <= 1'b1;
    end else if (i_clear) begin
      r_data     <= '0;
      r_occupied <= 1'b0;
    end
  end

  assign o_data     = r_data;
  assign o_occupied = r_occupied;

endmodule : pend_buf
`default_nettype wire

// File: rtl/pc_sel_mux.sv
`default_nettype none
// ============================================================================
// Module   : pc_sel_mux
// Brief    : Registered N-way PC select with stall support. A request seen
//            during a stall is parked in a one-entry buffer and drained when
//            the stall lifts, unless a fresh request arrives at that moment.
//            Out-of-range selects raise a sticky error flag.
// Revision : 1.0 - initial release
// ============================================================================
module pc_sel_mux
  import pc_sel_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NUM_IN    = 3,
  parameter int               SEL_W     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(c_PC_RESET_VAL)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    sel_valid,
  input  logic                    stall,
  output logic [WIDTH-1:0]        out,
  output logic                    out_valid,
  output logic                    pend,
  output logic                    err
);

  // Reject parameter sets the select logic is not built for.
  if (NUM_IN < 2 || NUM_IN > c_MAX_NUM_IN || SEL_W != $clog2(NUM_IN)) begin : g_bad_params
    $error("pc_sel_mux: NUM_IN must be 2..16 and SEL_W must equal clog2(NUM_IN)");
  end

  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic             r_err;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_in_range;
  logic             w_legal;
  logic             w_illegal;
  logic             w_pend_load;
  logic             w_pend_clear;
  logic [WIDTH-1:0] w_pend_data;
  logic             w_pend_occ;

  // Zero-extend sel so the range check also covers encodings >= NUM_IN.
  assign w_in_range = ({{(32-SEL_W){1'b0}}, sel} < 32'(NUM_IN));
  assign w_legal    = sel_valid &&  w_in_range;
  assign w_illegal  = sel_valid && !w_in_range;

  // Input multiplexer; out-of-range selects yield zero (never consumed).
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Park legal requests during a stall; once the stall lifts the buffer
  // is emptied whether it was drained or superseded by a new request.
  assign w_pend_load  = stall && w_legal;
  assign w_pend_clear = !stall && w_pend_occ;

  pend_buf #(
    .WIDTH (WIDTH)
  ) u_pend_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pend_load),
    .i_clear    (w_pend_clear),
    .i_data     (w_sel_data),
    .o_data     (w_pend_data),
    .o_occupied (w_pend_occ)
  );

  // Output register: a live request beats the parked one; stall freezes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out       <= RESET_VAL;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_illegal) begin
        r_err <= 1'b1;
      end
      if (!stall) begin
        if (w_legal) begin
          r_out       <= w_sel_data;
          r_out_valid <= 1'b1;
        end else if (w_pend_occ) begin
          r_out       <= w_pend_data;
          r_out_valid <= 1'b1;
        end
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign pend      = w_pend_occ;
  assign err       = r_err;

endmodule : pc_sel_mux
`default_nettype wire
